// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - BCD MM:SS countdown timer with start/pause/clear control
// Optional free-running 1 Hz blink output enabled by TIMER_COUNTER_BLINK_EN.
module timer_counter #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [7:0]  PRESET_MM = 8'h05,
  parameter logic [7:0]  PRESET_SS = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       finish,
  output logic       running,
  output logic       tick,
  output logic       clk1Hz
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] PRESET = {PRESET_MM, PRESET_SS};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [15:0]   digits, digits_nxt, digits_dec;
  logic          tick_nxt;

  // One-second BCD decrement; 00:00 is held rather than wrapping.
  always_comb begin
    digits_dec = digits;
    if (digits != 16'h0000) begin
      if (digits[3:0] != 4'd0) begin
        digits_dec[3:0] = digits[3:0] - 4'd1;
      end else begin
        digits_dec[3:0] = 4'd9;
        if (digits[7:4] != 4'd0) begin
          digits_dec[7:4] = digits[7:4] - 4'd1;
        end else begin
          digits_dec[7:4] = 4'd5;
          if (digits[11:8] != 4'd0) begin
            digits_dec[11:8] = digits[11:8] - 4'd1;
          end else begin
            digits_dec[11:8] = 4'd9;
            if (digits[15:12] != 4'd0) digits_dec[15:12] = digits[15:12] - 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre;
    digits_nxt = digits;
    tick_nxt   = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      pre_nxt    = '0;
      digits_nxt = PRESET;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start) begin
            pre_nxt   = '0;
            state_nxt = (PRESET == 16'h0000) ? DONE : RUN;
          end
        end
        RUN: begin
          // pause wins over a pending tick, so the decrement is simply skipped
          if (pause) begin
            state_nxt = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_nxt    = '0;
            tick_nxt   = 1'b1;
            digits_nxt = digits_dec;
            if (digits_dec == 16'h0000) state_nxt = DONE;
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        PAUSE: begin
          if (!pause && start) state_nxt = RUN;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pre     <= '0;
      digits  <= PRESET;
      tick    <= 1'b0;
      finish  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre     <= pre_nxt;
      digits  <= digits_nxt;
      tick    <= tick_nxt;
      finish  <= (state_nxt == DONE);
      running <= (state_nxt == RUN);
    end
  end

  assign {dig0, dig1, dig2, dig3} = digits;

`ifdef TIMER_COUNTER_BLINK_EN
  localparam int unsigned HALF = TICK_DIV / 2;
  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      clk1Hz    <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      clk1Hz    <= ~clk1Hz;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign clk1Hz = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter (presets 01:00, 00:02, 10:00)
module tb_timer_counter;

  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] d0 [3], d1 [3], d2 [3], d3 [3];
  logic fin [3], run [3], tk [3], blk [3];

  always #5 clk = ~clk;

  timer_counter #(.TICK_DIV(TD), .PRESET_MM(8'h01), .PRESET_SS(8'h00)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
    .dig0(d0[0]), .dig1(d1[0]), .dig2(d2[0]), .dig3(d3[0]),
    .finish(fin[0]), .running(run[0]), .tick(tk[0]), .clk1Hz(blk[0]));

  timer_counter #(.TICK_DIV(TD), .PRESET_MM(8'h00), .PRESET_SS(8'h02)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
    .dig0(d0[1]), .dig1(d1[1]), .dig2(d2[1]), .dig3(d3[1]),
    .finish(fin[1]), .running(run[1]), .tick(tk[1]), .clk1Hz(blk[1]));

  timer_counter #(.TICK_DIV(TD), .PRESET_MM(8'h10), .PRESET_SS(8'h00)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
    .dig0(d0[2]), .dig1(d1[2]), .dig2(d2[2]), .dig3(d3[2]),
    .finish(fin[2]), .running(run[2]), .tick(tk[2]), .clk1Hz(blk[2]));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: remaining time kept as plain seconds, shown as BCD on compare
  int psecs [3];
  int m_st [3], m_secs [3], m_pre [3];
  bit m_tick [3];
  int m_edges;

  typedef struct {
    int         reps;
    bit         c, p, s;
    bit         e_run, e_fin, e_tick;
    logic [15:0] e_dig;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_dig(input int i);
    return {d0[i], d1[i], d2[i], d3[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = S_IDLE;
      m_secs[i] = psecs[i];
      m_pre[i] = 0;
      m_tick[i] = 1'b0;
    end
    m_edges = 0;
  endtask

  task automatic model_edge();
    m_edges++;
    for (int i = 0; i < 3; i++) begin
      m_tick[i] = 1'b0;
      if (clear) begin
        m_st[i] = S_IDLE;
        m_secs[i] = psecs[i];
        m_pre[i] = 0;
      end else begin
        case (m_st[i])
          S_IDLE: if (start && !pause) begin
            m_pre[i] = 0;
            m_st[i] = (psecs[i] == 0) ? S_DONE : S_RUN;
          end
          S_RUN: begin
            if (pause) m_st[i] = S_PAUSE;
            else if (m_pre[i] == TD - 1) begin
              m_pre[i] = 0;
              m_secs[i] = m_secs[i] - 1;
              m_tick[i] = 1'b1;
              if (m_secs[i] == 0) m_st[i] = S_DONE;
            end else m_pre[i] = m_pre[i] + 1;
          end
          S_PAUSE: if (start && !pause) m_st[i] = S_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic exp_blk;
`ifdef TIMER_COUNTER_BLINK_EN
    exp_blk = 1'((m_edges / (TD / 2)) % 2);
`else
    exp_blk = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s u%0d digits", tag, i), dut_dig(i), to_bcd(m_secs[i]));
      check($sformatf("%s u%0d running", tag, i), run[i], m_st[i] == S_RUN);
      check($sformatf("%s u%0d finish", tag, i), fin[i], m_st[i] == S_DONE);
      check($sformatf("%s u%0d tick", tag, i), tk[i], m_tick[i]);
      check($sformatf("%s u%0d clk1Hz", tag, i), blk[i], exp_blk);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, " immediate"});
    @(posedge clk);
    #1;
    compare_all({tag, " hold"});
    reset_n = 1'b1;
  endtask

  initial begin
    psecs[0] = 60;
    psecs[1] = 2;
    psecs[2] = 600;
    model_reset();

    tbl.push_back('{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001});
    tbl.push_back('{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000});
    tbl.push_back('{2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002});

    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    check("reset u_a digits", dut_dig(0), 16'h0100);
    reset_n = 1'b1;

    // Start pulse, first tick 4 edges later; borrow chains on all presets
    start = 1'b1;
    step("start");
    start = 1'b0;
    check("start u_a running", run[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      step("pre-tick");
      check($sformatf("pre-tick%0d u_a tick", k), tk[0], 1'b0);
    end
    step("tick1");
    check("tick1 u_a tick", tk[0], 1'b1);
    check("tick1 u_a 00:59", dut_dig(0), 16'h0059);
    check("tick1 u_c 09:59", dut_dig(2), 16'h0959);
    check("tick1 u_b 00:01", dut_dig(1), 16'h0001);

    // Pause landing exactly on the tick cycle suppresses it
    repeat (3) step("to-edge");
    pause = 1'b1;
    step("pause@tick");
    check("pause@tick u_a tick", tk[0], 1'b0);
    check("pause@tick u_a digits", dut_dig(0), 16'h0059);
    check("pause@tick u_a running", run[0], 1'b0);
    step("paused");
    pause = 1'b0;
    start = 1'b1;
    step("resume");
    start = 1'b0;
    step("tick2");
    check("tick2 u_a 00:58", dut_dig(0), 16'h0058);
    check("tick2 u_b finish", fin[1], 1'b1);
    check("tick2 u_b 00:00", dut_dig(1), 16'h0000);

    // Reset mid-run abandons the count immediately
    step("run-on");
    async_reset("midrun reset");
    check("midrun reset u_a digits", dut_dig(0), 16'h0100);
    check("midrun reset u_b finish", fin[1], 1'b0);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        clear = tbl[i].c;
        pause = tbl[i].p;
        start = tbl[i].s;
        step($sformatf("tbl%0d.%0d", i, r));
        check($sformatf("tbl%0d.%0d u_b running", i, r), run[1], tbl[i].e_run);
        check($sformatf("tbl%0d.%0d u_b finish", i, r), fin[1], tbl[i].e_fin);
        check($sformatf("tbl%0d.%0d u_b tick", i, r), tk[1], tbl[i].e_tick);
        check($sformatf("tbl%0d.%0d u_b digits", i, r), dut_dig(1), tbl[i].e_dig);
      end
    end
    clear = 1'b0;
    pause = 1'b0;
    start = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      clear = ($urandom_range(0, 63) == 0);
      pause = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) async_reset($sformatf("rand reset %0d", k));
      step($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per one-second tick (minimum 2, even).
REQ-002 Parameter PRESET_MM, default 8'h05, preset minutes as two BCD digits {tens,units}.
REQ-003 Parameter PRESET_SS, default 8'h00, preset seconds as two BCD digits {tens,units}, tens <= 5.
REQ-004 clk  input  1  system clock, rising-edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level; start from IDLE or resume from PAUSE.
REQ-007 pause  input  1  level; suspend counting.
REQ-008 clear  input  1  level; synchronous reload of preset, return to IDLE.
REQ-009 dig0  output  4  BCD minutes tens.
REQ-010 dig1  output  4  BCD minutes units.
REQ-011 dig2  output  4  BCD seconds tens.
REQ-012 dig3  output  4  BCD seconds units.
REQ-013 finish  output  1  high while in DONE.
REQ-014 running  output  1  high while in RUN.
REQ-015 tick  output  1  one-cycle pulse per second decrement.
REQ-016 clk1Hz  output  1  50% duty 1 Hz blink wave for the text stage.

Function
REQ-017 States SHALL be IDLE, RUN, PAUSE, DONE.
REQ-018 Command priority SHALL be clear > pause > start, evaluated every cycle.
REQ-019 clear in any state: digits <= preset, prescaler <= 0, state <= IDLE on the next edge.
REQ-020 IDLE + start: RUN, prescaler <= 0; if preset is 00:00, go to DONE instead.
REQ-021 RUN + pause: PAUSE, prescaler and digits held.
REQ-022 PAUSE + start (pause low): RUN, prescaler resumes from its held value.
REQ-023 DONE SHALL ignore start and pause; only clear or reset exits.
REQ-024 In RUN, the prescaler counts 0..TICK_DIV-1; tick is asserted in the cycle the prescaler equals TICK_DIV-1, and the prescaler wraps to 0.
REQ-025 On tick, the MM:SS value SHALL decrement by one second in BCD:
  - dig3 decrements, wrapping 0 to 9 with a borrow.
  - dig2 wraps 0 to 5.
  - dig1 wraps 0 to 9.
  - dig0 decrements on a borrow and never underflows.
REQ-026 The edge that makes the value 00:00 SHALL also move the state to DONE.
  - finish is high from that same edge.
  - The digits hold 0000 thereafter.
REQ-027 A tick SHALL NOT be generated outside RUN.
REQ-028 pause asserted in the cycle tick would fire: the tick is suppressed and the digits are unchanged.
REQ-029 All outputs SHALL be registered; latency from a command to the state/output change is one clk edge.

Reset
REQ-030 reset_n low SHALL asynchronously force the following; release is synchronous to clk:
  - state IDLE.
  - digits = preset.
  - prescaler 0.
  - finish, running, tick and clk1Hz all 0.
REQ-031 Reset during RUN or DONE SHALL abandon the count with no residual tick or finish.

Configuration
REQ-032 Macro TIMER_COUNTER_BLINK_EN defined:
  - clk1Hz is a free-running square wave, independent of state.
  - It toggles every TICK_DIV/2 clk cycles from its own divider.
REQ-033 Macro TIMER_COUNTER_BLINK_EN undefined: clk1Hz is tied 0 and no blink divider is synthesized.

Verification (TICK_DIV=4)
REQ-034 Reset with PRESET 01:00, then start for one cycle -> running=1 next edge; the first tick occurs 4 cycles later; digits 0,0,5,9.
REQ-035 PRESET 00:02, start -> ticks give 00:01 then 00:00; finish=1 on the same edge as 0000; running=0; further start pulses leave finish=1.
REQ-036 PRESET 10:00, one tick -> 09:59; borrow chain across all four digits is correct.
REQ-037 Run 2 cycles, pause 10 cycles, resume -> the next tick arrives 2 cycles after resume; digits are frozen during pause.
REQ-038 clear asserted together with start in DONE -> IDLE with preset digits, finish=0; reset_n pulsed low mid-RUN -> immediate preset, outputs 0.
REQ-039 With TIMER_COUNTER_BLINK_EN -> clk1Hz period of 4 cycles, 2 high / 2 low; without it -> clk1Hz constant 0.
